// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, data access has priority over instruction fetch.
// Optional wait-timeout abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

  state_t      state, state_nxt;
  logic        ihit_nxt, dhit_nxt, ramREN_nxt, ramWEN_nxt, err_nxt;
  logic [31:0] iload_nxt, dload_nxt, ramaddr_nxt, ramstore_nxt;
  logic        expired;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt, wait_cnt_nxt;

  assign expired = (wait_cnt + 32'd1) >= 32'(TIMEOUT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) wait_cnt <= '0;
    else       wait_cnt <= wait_cnt_nxt;
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (state == IDLE)
      wait_cnt_nxt = '0;
    else if (ramstate != RAM_ACCESS && ramstate != RAM_ERROR && !expired)
      wait_cnt_nxt = wait_cnt + 32'd1;
  end
`else
  // Without the counter an access never expires; TIMEOUT has no effect.
  assign expired = 1'b0 & (TIMEOUT < 0);
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ihit     <= ihit_nxt;
      dhit     <= dhit_nxt;
      iload    <= iload_nxt;
      dload    <= dload_nxt;
      ramREN   <= ramREN_nxt;
      ramWEN   <= ramWEN_nxt;
      ramaddr  <= ramaddr_nxt;
      ramstore <= ramstore_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ihit_nxt     = 1'b0;
    dhit_nxt     = 1'b0;
    iload_nxt    = iload;
    dload_nxt    = dload;
    ramREN_nxt   = ramREN;
    ramWEN_nxt   = ramWEN;
    ramaddr_nxt  = ramaddr;
    ramstore_nxt = ramstore;
    err_nxt      = err;
    case (state)
      IDLE: begin
        // A requester's own hit cycle is masked: its enable is dropped on that edge.
        if ((dREN || dWEN) && !dhit) begin
          state_nxt    = DACC;
          ramaddr_nxt  = daddr;
          ramstore_nxt = dstore;
          ramWEN_nxt   = dWEN;
          ramREN_nxt   = !dWEN;
        end else if (iREN && !ihit) begin
          state_nxt   = IACC;
          ramaddr_nxt = iaddr;
          ramREN_nxt  = 1'b1;
          ramWEN_nxt  = 1'b0;
        end
      end
      DACC, IACC: begin
        if (ramstate == RAM_ACCESS || ramstate == RAM_ERROR || expired) begin
          state_nxt  = IDLE;
          ramREN_nxt = 1'b0;
          ramWEN_nxt = 1'b0;
          if (ramstate != RAM_ACCESS) err_nxt = 1'b1;
          if (state == DACC) begin
            dhit_nxt = 1'b1;
            if (ramstate != RAM_ACCESS) dload_nxt = ERR_WORD;
            else if (!ramWEN)           dload_nxt = ramload;
          end else begin
            ihit_nxt  = 1'b1;
            iload_nxt = (ramstate == RAM_ACCESS) ? ramload : ERR_WORD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

  localparam logic [31:0] ERR_W = 32'hBAD1BAD1;
  localparam int          TO    = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_vec = 0, n_miss = 0;
  int n_dhit = 0, n_acc = 0;

  mem_arbiter #(.TIMEOUT(TO), .ERR_WORD(ERR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // RAM responder: busy_n BUSY cycles after enables rise, then final_st.
  int         busy_n = 0;
  logic [1:0] final_st = 2'd2;
  int         wcnt = 0;
  logic       en_prev = 1'b0;
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      if (!en_prev) n_acc++;
      if (wcnt < busy_n) begin
        ramstate = 2'd1;
        ramload  = 32'hFFFF_FFFF;
      end else begin
        ramstate = final_st;
        ramload  = (final_st == 2'd2) ? mem_word(ramaddr) : 32'hFFFF_FFFF;
      end
      wcnt++;
    end else begin
      ramstate = 2'd0;
      ramload  = 32'hFFFF_FFFF;
      wcnt     = 0;
    end
    en_prev = ramREN || ramWEN;
    if (dhit) n_dhit++;
  end

  // Reference model: one pending transaction (kind 0 none, 1 load, 2 store, 3 fetch).
  int          m_kind, m_wait;
  logic        m_ihit, m_dhit, m_ren, m_wen, m_err;
  logic [31:0] m_iload, m_dload, m_addr, m_store;
  logic        m_done, m_abort;
  assign m_done  = (ramstate == 2'd2);
  assign m_abort = !m_done && (ramstate == 2'd3 || (TO_EN && m_wait + 1 >= TO));

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_kind <= 0; m_wait <= 0; m_ihit <= 0; m_dhit <= 0; m_ren <= 0; m_wen <= 0;
      m_err <= 0; m_iload <= 0; m_dload <= 0; m_addr <= 0; m_store <= 0;
    end else begin
      m_ihit <= 0;
      m_dhit <= 0;
      if (m_kind == 0) begin
        m_wait <= 0;
        if ((dREN || dWEN) && !m_dhit) begin
          m_kind  <= dWEN ? 2 : 1;
          m_ren   <= !dWEN;
          m_wen   <= dWEN;
          m_addr  <= daddr;
          m_store <= dstore;
        end else if (iREN && !m_ihit) begin
          m_kind <= 3;
          m_ren  <= 1;
          m_wen  <= 0;
          m_addr <= iaddr;
        end
      end else if (m_done || m_abort) begin
        m_kind <= 0;
        m_ren  <= 0;
        m_wen  <= 0;
        if (m_abort) m_err <= 1;
        if (m_kind == 3) begin
          m_ihit  <= 1;
          m_iload <= m_abort ? ERR_W : ramload;
        end else begin
          m_dhit <= 1;
          if (m_abort)          m_dload <= ERR_W;
          else if (m_kind == 1) m_dload <= ramload;
        end
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  always @(negedge CLK) begin
    check("ihit", ihit, m_ihit);
    check("dhit", dhit, m_dhit);
    check("no_overlap", ihit & dhit, 0);
    check("ramREN", ramREN, m_ren);
    check("ramWEN", ramWEN, m_wen);
    check("ramaddr", ramaddr, m_addr);
    check("ramstore", ramstore, m_store);
    check("err", err, m_err);
    if (ihit) check("iload", iload, m_iload);
    if (dhit) check("dload", dload, m_dload);
  end

  task automatic wait_hit(input bit data, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      n++;
      if (data ? dhit : ihit) return;
    end
    check(data ? "dhit_wait_bound" : "ihit_wait_bound", 0, 1);
  endtask

  int          n, nd0, acc0, idle;
  logic [31:0] prev_dload;

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 0;
    repeat (3) @(negedge CLK);
    check("rst_outputs", {ihit, dhit, ramREN, ramWEN, err}, 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_dload", dload, 0);
    nRST = 1;

    // reset in the middle of a data access
    @(negedge CLK); busy_n = 50; dREN = 1; daddr = 32'h80;
    repeat (3) @(negedge CLK);
    check("mid_ramREN", ramREN, 1);
    nRST = 0; dREN = 0;
    #1;
    check("midrst_outputs", {ihit, dhit, ramREN, ramWEN, err}, 0);
    check("midrst_ramaddr", ramaddr, 0);
    nd0 = n_dhit;
    @(negedge CLK); nRST = 1; busy_n = 0;
    iREN = 1; iaddr = 32'h40;
    wait_hit(0, n); iREN = 0;
    check("min_latency", n, 2);
    check("rst_iload", iload, mem_word(32'h40));
    check("midrst_no_dhit", n_dhit, nd0);

    // simultaneous requests: data first, exactly one idle cycle, then fetch
    @(negedge CLK); busy_n = 2;
    iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h300;
    wait_hit(1, n); dREN = 0;
    check("sim_d_latency", n, 4);
    check("sim_dload", dload, mem_word(32'h300));
    check("sim_ihit_low", ihit, 0);
    idle = (ramREN || ramWEN) ? 0 : 1;
    for (int i = 0; i < 10 && !(ramREN || ramWEN); i++) begin
      @(negedge CLK);
      if (!(ramREN || ramWEN)) idle++;
    end
    check("sim_idle_cycles", idle, 1);
    check("sim_fetch_addr", ramaddr, 32'h200);
    wait_hit(0, n); iREN = 0;
    check("sim_iload", iload, mem_word(32'h200));

    // dREN held through its hit cycle: only one access
    @(negedge CLK); busy_n = 1; dREN = 1; daddr = 32'h180;
    acc0 = n_acc; nd0 = n_dhit;
    wait_hit(1, n);
    @(negedge CLK); dREN = 0;
    repeat (4) @(negedge CLK);
    check("mask_accesses", n_acc - acc0, 1);
    check("mask_dhits", n_dhit - nd0, 1);
    prev_dload = mem_word(32'h180);

    // write with operands changing mid-access
    @(negedge CLK); busy_n = 3; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    @(negedge CLK);
    @(negedge CLK); daddr = 32'h999; dstore = 32'h0;
    @(negedge CLK);
    check("wr_ramaddr", ramaddr, 32'h100);
    check("wr_ramstore", ramstore, 32'hDEADBEEF);
    check("wr_enables", {ramREN, ramWEN}, 2'b01);
    wait_hit(1, n); dWEN = 0;
    check("wr_dload_held", dload, prev_dload);
    @(negedge CLK);
    check("wr_dhit_one_cycle", dhit, 0);

    // RAM ERROR during a fetch
    @(negedge CLK); busy_n = 1; final_st = 2'd3; iREN = 1; iaddr = 32'h44;
    wait_hit(0, n); iREN = 0;
    check("err_iload", iload, 32'hBAD1BAD1);
    check("err_flag", err, 1);
    @(negedge CLK); final_st = 2'd2; busy_n = 0; dREN = 1; daddr = 32'h20;
    wait_hit(1, n); dREN = 0;
    check("err_then_dload", dload, mem_word(32'h20));
    check("err_sticky", err, 1);

    // RAM stuck BUSY
    @(negedge CLK); busy_n = 100000; dREN = 1; daddr = 32'h60;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_hit(1, n); dREN = 0;
    check("to_latency", n, 9);
    check("to_dload", dload, 32'hBAD1BAD1);
    check("to_err", err, 1);
`else
    nd0 = n_dhit;
    repeat (100) @(negedge CLK);
    check("noto_pending_dhit", n_dhit - nd0, 0);
    check("noto_ramREN", ramREN, 1);
`endif
    nRST = 0; dREN = 0;
    @(negedge CLK); nRST = 1; busy_n = 0;
    @(negedge CLK);
    check("err_cleared_by_reset", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the pipeline's instruction fetch and the memory stage's data access. It serialises both request streams onto one RAM port and returns registered `ihit`/`dhit` pulses with load data, which gate the pipeline-register updates. Data requests win over instruction fetch so an in-flight load/store never starves behind fetch.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles an access may wait for `ramstate==ACCESS` before it is aborted; active only with `MEM_ARB_TIMEOUT_EN`.
- `ERR_WORD`, 32'hBAD1BAD1: load value returned on an aborted access.

Ports:
- Reset is asynchronous, active-low: `nRST`. The block has one clock, `CLK`.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `iREN` in 1: instruction fetch request.
- `iaddr` in 32: fetch address.
- `ihit` out 1: one-cycle fetch-complete pulse.
- `iload` out 32: fetched word, valid while `ihit`=1.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dhit` out 1: one-cycle data-complete pulse.
- `dload` out 32: read word, valid while `dhit`=1.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: RAM status. 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
- `err` out 1: sticky error flag. Cleared only by reset.

## Operation
- FSM states: IDLE, DACC, IACC. All outputs are registered.
- IDLE behaviour:
  - Eligible data request: (`dREN|dWEN`) with `dhit`=0. Latch `daddr`, `dstore` and `dWEN`, then go to DACC.
  - Otherwise, eligible fetch: `iREN` with `ihit`=0. Latch `iaddr`, then go to IACC.
  - Otherwise stay in IDLE.
- Hit-cycle masking: a requester's enable is ignored during its own hit cycle, because the stage drops the enable on that edge.
- If `dREN` and `dWEN` are both high, the write wins.
- DACC: drive `ramaddr`=latched addr, `ramstore`=latched data, and `ramWEN`/`ramREN` per the latched op. Operand changes mid-access are ignored.
- IACC: drive `ramREN`=1, `ramWEN`=0, `ramaddr`=latched `iaddr`.
- On `ramstate==ACCESS` in DACC/IACC:
  - Capture `ramload` into `dload`/`iload`.
  - Pulse `dhit`/`ihit` next cycle.
  - Return to IDLE and deassert the RAM enables.
- On writes, `dload` holds its previous value.
- FREE/BUSY in DACC/IACC: hold state and outputs.
- ERROR in DACC/IACC: abort the access.
  - Set `err`.
  - Load `ERR_WORD` into the requester's load register.
  - Pulse the hit and return to IDLE.
- `ihit` and `dhit` are never high in the same cycle.
- Reset value of every output: 0 (`ihit`, `dhit`, `iload`, `dload`, `ramREN`, `ramWEN`, `ramaddr`, `ramstore`, `err`). State resets to IDLE; the wait counter resets to 0.
- Reset mid-access drops the access immediately; no hit pulse is produced.

## Timing
- Request sampled at edge N means the RAM enables are high from cycle N+1.
- `ramstate==ACCESS` sampled at edge K means the hit is high in cycle K+1 and the enables are low in cycle K+1.
- Minimum latency, request to hit: 2 cycles (ACCESS in the first enabled cycle).
- Back-to-back: a new request can be sampled in the hit cycle by the other requester, so RAM is idle at most 1 cycle between accesses.
- A fetch waiting behind a data access is granted at the data hit edge. This holds even if `dREN` is still high, because of masking.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A wait counter increments each cycle in DACC/IACC without ACCESS, and clears on entering IDLE.
  - When the count reaches `TIMEOUT`, the access is aborted exactly like ERROR: `err`=1, `ERR_WORD` returned, hit pulse.
- `MEM_ARB_TIMEOUT_EN` undefined: there is no counter and accesses wait indefinitely.

## Test plan
- Reset:
  - Assert `nRST`=0 mid-DACC, then release.
  - Required: all outputs 0, state IDLE, no `dhit`.
  - A following `iREN` at addr 0x40 is served normally.
- Simultaneous requests:
  - `iREN` and `dREN` both high at one edge; RAM returns ACCESS after 2 BUSY cycles.
  - Required: `dhit` first with `dload`=RAM word.
  - `ihit` follows; there is exactly 1 idle cycle and no overlapping hits.
- Write:
  - `dWEN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF; `daddr` changes during BUSY.
  - Required: `ramaddr` stays 0x100 and `ramstore` stays 0xDEADBEEF; `dhit` 1 cycle; `dload` unchanged.
- Masking:
  - `dREN` held high through the `dhit` cycle, deasserted one cycle later.
  - Required: exactly one data access.
- ERROR:
  - `ramstate`=3 during IACC.
  - Required: `ihit`=1 with `iload`=0xBAD1BAD1; `err`=1 and sticky until reset.
- Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=8):
  - `ramstate` held BUSY.
  - Required: `dhit` with `ERR_WORD` 8 cycles after grant; `err`=1.
  - Without the macro, the access is still pending after 100 cycles.
